dma_multichannel: RTL and testbench

Parametrised multi-channel DMA engine for the pipelined CPU system, replacing the single-channel, fixed-length DMA. Up to NUM_CH device channels each accept a (base address, block count) command. The engine arbitrates between pending channels round-robin and acquires the memory bus via the BR/BG handshake with the CPU. It writes each block of BURST_WORDS words to memory and raises a per-channel, acknowledgeable completion interrupt.

---
 rtl/dma_multichannel.sv | 187 ++++++++++++++++++
 tb/tb_dma_multichannel.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_multichannel.sv
// Multi-channel block DMA: per-channel command registers, round-robin channel
// selection, BR/BG bus handshake and sticky per-channel completion interrupts.
module dma_multichannel #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned BURST_WORDS = 4,
  parameter int unsigned MAX_BLOCKS  = 3,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LEN_W  = $clog2(MAX_BLOCKS + 1),
  localparam int unsigned OFF_W  = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1,
  localparam int unsigned DATA_W = BURST_WORDS * WORD_SIZE
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  output logic [CH_W-1:0]      dev_ch,
  input  logic [DATA_W-1:0]    edata,
  output logic                 WRITE,
  output logic [WORD_SIZE-1:0] addr,
  output logic [DATA_W-1:0]    data,
  output logic [OFF_W-1:0]     offset,
  output logic [NUM_CH-1:0]    irq,
  input  logic [NUM_CH-1:0]    irq_ack,
  output logic                 interrupt
);

  localparam int unsigned BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]                       state, state_d;
  logic [NUM_CH-1:0]                pending, pending_d;
  logic [NUM_CH-1:0][WORD_SIZE-1:0] base, base_d;
  logic [NUM_CH-1:0][LEN_W-1:0]     len, len_d;
  logic [CH_W-1:0]                  cur_ch, cur_ch_d;
  logic [CH_W-1:0]                  rr_ptr, rr_ptr_d;
  logic [OFF_W-1:0]                 blk, blk_d;
  logic [BEAT_W-1:0]                beat, beat_d;
  logic                             br_d;
  logic [NUM_CH-1:0]                irq_d;
  logic [NUM_CH-1:0]                done_mask;
  logic                             accept;
  logic [LEN_W-1:0]                 len_clamped;
  logic                             sel_found;
  logic [CH_W-1:0]                  sel_ch;
  logic                             last_beat;
  logic                             last_blk;

  function automatic logic [CH_W-1:0] ch_wrap(input int unsigned v);
    return CH_W'(v % NUM_CH);
  endfunction

  assign cmd_ready = ~pending[cmd_ch];
  assign accept    = cmd_valid & cmd_ready;

  // Clamp only exists when the length field can encode more than MAX_BLOCKS.
  if ((2 ** LEN_W - 1) > MAX_BLOCKS) begin : g_clamp
    assign len_clamped = (cmd_len > LEN_W'(MAX_BLOCKS)) ? LEN_W'(MAX_BLOCKS) : cmd_len;
  end else begin : g_noclamp
    assign len_clamped = cmd_len;
  end

  // Round-robin pick: first pending channel at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!sel_found && pending[ch_wrap(32'(rr_ptr) + i)]) begin
        sel_found = 1'b1;
        sel_ch    = ch_wrap(32'(rr_ptr) + i);
      end
    end
  end

  always_comb begin
    state_d   = state;
    pending_d = pending;
    base_d    = base;
    len_d     = len;
    cur_ch_d  = cur_ch;
    rr_ptr_d  = rr_ptr;
    blk_d     = blk;
    beat_d    = beat;
    br_d      = BR;
    done_mask = '0;
    last_beat = (beat == BEAT_W'(BURST_WORDS - 1));
    last_blk  = ((LEN_W'(blk) + LEN_W'(1)) == len[cur_ch]);

    case (state)
      S_IDLE: begin
        if (sel_found) begin
          cur_ch_d = sel_ch;
          if (len[sel_ch] == '0) begin
            done_mask[sel_ch] = 1'b1;
            rr_ptr_d          = ch_wrap(32'(sel_ch) + 1);
          end else begin
            br_d    = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (BG) begin
          blk_d   = '0;
          beat_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Losing the grant restarts the current block from its first beat.
        if (!BG) begin
          beat_d = '0;
        end else if (last_beat) begin
          beat_d = '0;
          if (last_blk) begin
            br_d    = 1'b0;
            state_d = S_REL;
          end else begin
            blk_d = blk + OFF_W'(1);
          end
        end else begin
          beat_d = beat + BEAT_W'(1);
        end
      end
      S_REL: begin
        if (!BG) begin
          done_mask[cur_ch] = 1'b1;
          rr_ptr_d          = ch_wrap(32'(cur_ch) + 1);
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = pending_d & ~done_mask;
    if (accept) begin
      pending_d[cmd_ch] = 1'b1;
      base_d[cmd_ch]    = cmd_addr;
      len_d[cmd_ch]     = len_clamped;
    end
    // A completion on the same edge as an acknowledge keeps the flag set.
    irq_d = (irq & ~irq_ack) | done_mask;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= S_IDLE;
      pending <= '0;
      base    <= '0;
      len     <= '0;
      cur_ch  <= '0;
      rr_ptr  <= '0;
      blk     <= '0;
      beat    <= '0;
      BR      <= 1'b0;
      irq     <= '0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      base    <= base_d;
      len     <= len_d;
      cur_ch  <= cur_ch_d;
      rr_ptr  <= rr_ptr_d;
      blk     <= blk_d;
      beat    <= beat_d;
      BR      <= br_d;
      irq     <= irq_d;
    end
  end

  assign WRITE     = (state == S_XFER) && BG;
  assign data      = WRITE ? edata : '0;
  assign addr      = base[cur_ch] + WORD_SIZE'(blk) * WORD_SIZE'(BURST_WORDS);
  assign offset    = blk;
  assign dev_ch    = cur_ch;
  assign interrupt = |irq;

endmodule

// File: tb/tb_dma_multichannel.sv
// Directed bench for dma_multichannel: CPU grant responder, write-cycle log
// and hand-computed expected address/offset/channel sequences.
module tb_dma_multichannel;

  localparam logic [63:0] EDATA = 64'hA1B2_C3D4_E5F6_0718;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [0:0]  cmd_ch;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        cmd_ready;
  logic        BR;
  logic        BG;
  logic [0:0]  dev_ch;
  logic [63:0] edata;
  logic        WRITE;
  logic [15:0] addr;
  logic [63:0] data;
  logic [1:0]  offset;
  logic [1:0]  irq;
  logic [1:0]  irq_ack;
  logic        interrupt;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  logic [31:0] wlog[$];
  int          wcyc[$];
  logic        brh[$];
  int          data_bad = 0;
  logic [31:0] exp_q[$];

  dma_multichannel #(
    .WORD_SIZE(16), .NUM_CH(2), .BURST_WORDS(4), .MAX_BLOCKS(3)
  ) dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .BR(BR), .BG(BG), .dev_ch(dev_ch), .edata(edata), .WRITE(WRITE),
    .addr(addr), .data(data), .offset(offset), .irq(irq),
    .irq_ack(irq_ack), .interrupt(interrupt)
  );

  always #5 CLK = ~CLK;

  // Mid-cycle sampling of every write beat and of BR.
  always @(negedge CLK) begin
    cyc++;
    brh.push_back(BR);
    if (WRITE) begin
      wlog.push_back({8'(dev_ch), 8'(offset), addr});
      wcyc.push_back(cyc);
      if (data !== edata) data_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic ch, input logic [15:0] a, input logic [1:0] l);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic add_exp(input int dev, input int off, input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(dev), 8'(off), a});
  endtask

  task automatic check_log(input string tag, input int lo);
    check({tag, " count"}, 32'(wlog.size() - lo), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (lo + i < wlog.size())
        check($sformatf("%s log[%0d]", tag, i), wlog[lo + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " BR"},        32'(BR),        32'd0);
    check({tag, " WRITE"},     32'(WRITE),     32'd0);
    check({tag, " addr"},      32'(addr),      32'd0);
    check({tag, " data"},      32'(data != 64'd0), 32'd0);
    check({tag, " offset"},    32'(offset),    32'd0);
    check({tag, " dev_ch"},    32'(dev_ch),    32'd0);
    check({tag, " irq"},       32'(irq),       32'd0);
    check({tag, " interrupt"}, 32'(interrupt), 32'd0);
  endtask

  // CPU model: grants one cycle after BR, optional grant drop, optional
  // acknowledge pulse aligned with the completion edge.
  task automatic serve(input int n, input int drop_after, input logic [1:0] ack_mask);
    int   lo;
    int   hold;
    bit   dropped;
    logic prev_br;
    lo = wlog.size();
    hold = 0;
    dropped = 1'b0;
    prev_br = BR;
    for (int k = 0; k < n; k++) begin
      if (drop_after > 0 && !dropped && (wlog.size() - lo) >= drop_after) begin
        dropped = 1'b1;
        hold    = 3;
        BG      = 1'b0;
        #1;
        check("drop WRITE", 32'(WRITE), 32'd0);
        check("drop BR",    32'(BR),    32'd1);
      end
      if (hold > 0) begin
        BG = 1'b0;
        hold--;
      end else begin
        BG = BR;
      end
      irq_ack = (prev_br && !BR) ? ack_mask : 2'b00;
      prev_br = BR;
      tick();
    end
    irq_ack = 2'b00;
  endtask

  initial begin
    int lo;
    int c0;
    int c1;
    bit gap_low;

    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_addr = '0; cmd_len = '0;
    BG = 1'b0; irq_ack = '0; edata = EDATA;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("reset");
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);

    // Single channel, three blocks.
    lo = wlog.size();
    send_cmd(1'b0, 16'h0100, 2'd3);
    check("t1 cmd_ready busy", 32'(cmd_ready), 32'd0);
    check("t1 BR after accept", 32'(BR), 32'd0);
    serve(20, 0, 2'b00);
    add_exp(0, 0, 16'h0100, 4);
    add_exp(0, 1, 16'h0104, 4);
    add_exp(0, 2, 16'h0108, 4);
    if (wlog.size() >= lo + 12)
      check("t1 contiguous", 32'(wcyc[lo + 11] - wcyc[lo]), 32'd11);
    check_log("t1", lo);
    check("t1 BR", 32'(BR), 32'd0);
    check("t1 irq", 32'(irq), 32'd1);
    check("t1 interrupt", 32'(interrupt), 32'd1);
    irq_ack = 2'b01;
    tick();
    irq_ack = 2'b00;
    check("t1 irq acked", 32'(irq), 32'd0);
    check("t1 interrupt acked", 32'(interrupt), 32'd0);

    // Two channels queued back to back.
    lo = wlog.size();
    send_cmd(1'b0, 16'h0200, 2'd1);
    send_cmd(1'b1, 16'h0300, 2'd2);
    serve(30, 0, 2'b00);
    gap_low = 1'b0;
    if (wlog.size() >= lo + 5) begin
      c0 = wcyc[lo + 3];
      c1 = wcyc[lo + 4];
      for (int c = c0 + 1; c < c1; c++) if (brh[c - 1] == 1'b0) gap_low = 1'b1;
    end
    check("t2 BR gap", 32'(gap_low), 32'd1);
    add_exp(0, 0, 16'h0200, 4);
    add_exp(1, 0, 16'h0300, 4);
    add_exp(1, 1, 16'h0304, 4);
    check_log("t2", lo);
    check("t2 irq", 32'(irq), 32'd3);
    irq_ack = 2'b11;
    tick();
    irq_ack = 2'b00;
    check("t2 irq acked", 32'(irq), 32'd0);

    // Grant dropped mid block 1: the block restarts from beat 0.
    lo = wlog.size();
    send_cmd(1'b0, 16'h0100, 2'd3);
    serve(30, 6, 2'b00);
    add_exp(0, 0, 16'h0100, 4);
    add_exp(0, 1, 16'h0104, 2);
    add_exp(0, 1, 16'h0104, 4);
    add_exp(0, 2, 16'h0108, 4);
    check_log("t3", lo);
    check("t3 irq", 32'(irq), 32'd1);
    irq_ack = 2'b01;
    tick();
    irq_ack = 2'b00;

    // Zero-length command completes without a bus request.
    lo = wlog.size();
    send_cmd(1'b1, 16'h0AAA, 2'd0);
    check("t4 irq before", 32'(irq), 32'd0);
    BG = 1'b0;
    tick();
    check("t4 irq len0", 32'(irq), 32'd2);
    check("t4 BR len0", 32'(BR), 32'd0);
    cmd_ch = 1'b1;
    #1;
    check("t4 cmd_ready ch1", 32'(cmd_ready), 32'd1);
    tick();
    check("t4 BR still low", 32'(BR), 32'd0);
    irq_ack = 2'b10;
    tick();
    irq_ack = 2'b00;
    check("t4 irq acked", 32'(irq), 32'd0);

    // Command to the channel in service is refused.
    send_cmd(1'b0, 16'h0400, 2'd2);
    serve(5, 0, 2'b00);
    BG = BR;
    cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_addr = 16'h0500; cmd_len = 2'd1;
    #1;
    check("t4 cmd_ready busy", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    serve(25, 0, 2'b00);
    add_exp(0, 0, 16'h0400, 4);
    add_exp(0, 1, 16'h0404, 4);
    check_log("t4", lo);
    check("t4 irq", 32'(irq), 32'd1);
    cmd_ch = 1'b0;
    #1;
    check("t4 nothing pending", 32'(cmd_ready), 32'd1);

    // Address wrap, acknowledge on the completion edge (irq[0] still set).
    lo = wlog.size();
    send_cmd(1'b0, 16'hFFFC, 2'd2);
    serve(25, 0, 2'b01);
    add_exp(0, 0, 16'hFFFC, 4);
    add_exp(0, 1, 16'h0000, 4);
    check_log("t5", lo);
    check("t5 irq set wins", 32'(irq), 32'd1);

    // Reset during a transfer with a second channel queued.
    send_cmd(1'b0, 16'h0600, 2'd3);
    send_cmd(1'b1, 16'h0700, 2'd1);
    serve(5, 0, 2'b00);
    check("t6 in transfer", 32'(WRITE), 32'd1);
    reset = 1'b1;
    BG = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t6");
    cmd_ch = 1'b0;
    #1;
    check("t6 ch0 cleared", 32'(cmd_ready), 32'd1);
    cmd_ch = 1'b1;
    #1;
    check("t6 ch1 cleared", 32'(cmd_ready), 32'd1);
    BG = 1'b0;
    lo = wlog.size();
    serve(10, 0, 2'b00);
    check_log("t6 idle", lo);
    check("t6 BR idle", 32'(BR), 32'd0);
    lo = wlog.size();
    send_cmd(1'b1, 16'h0800, 2'd1);
    serve(20, 0, 2'b00);
    add_exp(1, 0, 16'h0800, 4);
    check_log("t6 after", lo);
    check("t6 irq", 32'(irq), 32'd2);
    check("t6 interrupt", 32'(interrupt), 32'd1);

    check("write data", 32'(data_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
